writeback_stage: RTL and testbench
==================================

# writeback_stage

Final (WB) stage of the five-stage pipeline. It holds the MEM/WB pipeline register, selects the write-back value and drives the register-file write port (regWrite, WA, WD) that Decode reads through. Dual-destination instructions (SWAP) need two register writes through the single write port, so the block serialises them and stalls upstream for one cycle. It also counts retired instructions.

## Interface
Parameters:
- DATA_W, 16, register/data width
- ADDR_W, 3, register address width (8 registers)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (rst=0 resets on the next rising clk edge)
- in_valid  in  1  MEM stage presents an instruction
- WB_signals  in  3  {regWrite, WBsel[1:0]}; WBsel: 00 ALU result, 01 memory data, 10 immediate, 11 input port
- dual  in  1  instruction writes two registers (SWAP)
- dst1  in  ADDR_W  first destination register
- dst2  in  ADDR_W  second destination register (used only when dual=1)
- alu_result  in  DATA_W  ALU result / first SWAP value
- alu_result2  in  DATA_W  second SWAP value
- mem_data  in  DATA_W  data-memory read value
- Imm  in  DATA_W  immediate
- in_port  in  DATA_W  input-port value
- stall  out  1  registered; upstream must hold its outputs while 1
- regWrite  out  1  register-file write enable (registered)
- WA  out  ADDR_W  register-file write address (registered)
- WD  out  DATA_W  register-file write data (registered)
- retired  out  16  retired-instruction counter, wraps 16'hFFFF -> 0

## Operation
- Reset values: stall=0, regWrite=0, WA=0, WD=0, retired=0, state=IDLE.
- Accept: on a rising edge with rst=1, stall=0 and in_valid=1, the instruction is captured.
- Bubble: with in_valid=0 (and stall=0), the next cycle gives regWrite=0; WA/WD hold their previous values.
- First write (state IDLE -> IDLE or SECOND): regWrite<=WB_signals[2], WA<=dst1, WD<=mux(WBsel). retired increments by 1 at the same edge, including when regWrite=0 (e.g. a store).
- Dual: if dual=1 and WB_signals[2]=1 at accept, alu_result2 and dst2 are saved, state<=SECOND and stall<=1.
- Dual with regWrite=0: treated as single; no second write, no stall.
- In SECOND, on the next edge: regWrite<=1, WA<=dst2, WD<=saved alu_result2, stall<=0, state<=IDLE. retired does not increment. Inputs are ignored during this edge.
- dst1==dst2: both writes are issued in order; the register file ends holding alu_result2.
- WBsel is ignored for the second write; the data is always alu_result2.
- Reset while in SECOND: the pending second write is dropped; all outputs take their reset values.

## Timing
- Latency: input accepted at edge N gives write-port outputs valid for cycle N..N+1. The register file commits at edge N+1.
- Dual: the second write is presented at edge N+1 and committed at edge N+2. stall is high exactly one cycle (N to N+1).
- Throughput: 1 instruction per cycle for singles, 1 per 2 cycles for duals.
- stall is registered only (no combinational path from in_valid).

## Test plan
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> regWrite=0, WA=0, WD=0, stall=0, retired=0.
- WBsel sweep: dst1=3; alu=16'h1111, mem=16'h2222, Imm=16'h3333, in_port=16'h4444, WBsel 00..11 on consecutive cycles, regWrite=1 -> WA=3 and WD=1111, 2222, 3333, 4444 on successive cycles; retired=4.
- SWAP: dual=1, dst1=1, dst2=2, alu=16'hAAAA, alu2=16'h5555 -> cycle 1: WA=1, WD=AAAA, stall=1; cycle 2: WA=2, WD=5555, stall=0; retired increments once.
- Stall hold: during a SWAP, change the inputs to a new single instruction (dst1=4, alu=16'h0F0F) on the stall cycle -> it is ignored on that edge and accepted on the following edge (WA=4, WD=0F0F).
- Edge cases: dual=1 with regWrite=0 -> no write and no stall. retired preloaded to 16'hFFFF by 65535 singles, then one more -> retired=0.
- Reset mid-SWAP: assert rst=0 in the SECOND cycle -> no write to dst2; outputs go to their reset values.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage
// Write-back stage of the five-stage pipeline. Holds the MEM/WB pipeline
// register, selects the write-back value and drives the single register-file
// write port. Dual-destination instructions (SWAP) are split into two writes
// on consecutive cycles; upstream is stalled for the cycle of the second write.
// Also counts retired instructions.
//
// Ports
//   clk          pipeline clock, rising edge
//   rst          synchronous active-low reset
//   in_valid     MEM stage presents an instruction
//   WB_signals   {regWrite, WBsel[1:0]}; WBsel 00 ALU, 01 mem, 10 imm, 11 in_port
//   dual         instruction writes two registers (SWAP)
//   dst1, dst2   first / second destination register
//   alu_result   ALU result / first SWAP value
//   alu_result2  second SWAP value
//   mem_data     data-memory read value
//   Imm          immediate
//   in_port      input-port value
//   stall        registered; upstream holds its outputs while high
//   regWrite     register-file write enable
//   WA, WD       register-file write address / data
//   retired      retired-instruction counter, wraps to 0
//
// state  | meaning
// IDLE   | accepting instructions; outputs reflect last accepted write
// SECOND | second SWAP write pending; it is issued on the next edge
module writeback_stage #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [2:0]        WB_signals,
   input  logic              dual,
   input  logic [ADDR_W-1:0] dst1,
   input  logic [ADDR_W-1:0] dst2,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] alu_result2,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] Imm,
   input  logic [DATA_W-1:0] in_port,
   output logic              stall,
   output logic              regWrite,
   output logic [ADDR_W-1:0] WA,
   output logic [DATA_W-1:0] WD,
   output logic [15:0]       retired
);

   localparam logic IDLE   = 1'b0;
   localparam logic SECOND = 1'b1;

   logic              state_q,      state_d;
   logic              stall_q,      stall_d;
   logic              reg_write_q,  reg_write_d;
   logic [ADDR_W-1:0] wa_q,         wa_d;
   logic [DATA_W-1:0] wd_q,         wd_d;
   logic [15:0]       retired_q,    retired_d;
   logic [ADDR_W-1:0] dst2_sv_q,    dst2_sv_d;
   logic [DATA_W-1:0] data2_sv_q,   data2_sv_d;
   logic [DATA_W-1:0] wb_mux;

   always_comb begin
      wb_mux = alu_result;
      case (WB_signals[1:0])
         2'b00:   wb_mux = alu_result;
         2'b01:   wb_mux = mem_data;
         2'b10:   wb_mux = Imm;
         default: wb_mux = in_port;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      stall_d     = stall_q;
      reg_write_d = 1'b0;
      wa_d        = wa_q;
      wd_d        = wd_q;
      retired_d   = retired_q;
      dst2_sv_d   = dst2_sv_q;
      data2_sv_d  = data2_sv_q;

      if (state_q == SECOND) begin
         // Inputs are ignored here: upstream is holding behind stall.
         reg_write_d = 1'b1;
         wa_d        = dst2_sv_q;
         wd_d        = data2_sv_q;
         stall_d     = 1'b0;
         state_d     = IDLE;
      end else if (in_valid) begin
         reg_write_d = WB_signals[2];
         wa_d        = dst1;
         wd_d        = wb_mux;
         retired_d   = retired_q + 16'd1;
         stall_d     = 1'b0;
         // A dual instruction that does not write is just a single.
         if (dual && WB_signals[2]) begin
            dst2_sv_d  = dst2;
            data2_sv_d = alu_result2;
            stall_d    = 1'b1;
            state_d    = SECOND;
         end
      end else begin
         stall_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         stall_q     <= 1'b0;
         reg_write_q <= 1'b0;
         wa_q        <= '0;
         wd_q        <= '0;
         retired_q   <= '0;
         dst2_sv_q   <= '0;
         data2_sv_q  <= '0;
      end else begin
         state_q     <= state_d;
         stall_q     <= stall_d;
         reg_write_q <= reg_write_d;
         wa_q        <= wa_d;
         wd_q        <= wd_d;
         retired_q   <= retired_d;
         dst2_sv_q   <= dst2_sv_d;
         data2_sv_q  <= data2_sv_d;
      end
   end

   assign stall    = stall_q;
   assign regWrite = reg_write_q;
   assign WA       = wa_q;
   assign WD       = wd_q;
   assign retired  = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [2:0]  WB_signals;
   logic        dual;
   logic [2:0]  dst1, dst2;
   logic [15:0] alu_result, alu_result2, mem_data, Imm, in_port;
   logic        stall, regWrite;
   logic [2:0]  WA;
   logic [15:0] WD;
   logic [15:0] retired;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   writeback_stage #(.DATA_W(16), .ADDR_W(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .WB_signals(WB_signals),
      .dual(dual), .dst1(dst1), .dst2(dst2), .alu_result(alu_result),
      .alu_result2(alu_result2), .mem_data(mem_data), .Imm(Imm),
      .in_port(in_port), .stall(stall), .regWrite(regWrite), .WA(WA),
      .WD(WD), .retired(retired)
   );

   // Reference model: a queue of register writes still owed to the file.
   typedef struct {
      logic [2:0]  a;
      logic [15:0] d;
   } wr_t;
   wr_t         pend[$];
   logic        exp_rw, exp_stall;
   logic [2:0]  exp_wa;
   logic [15:0] exp_wd;
   int          exp_ret;

   task automatic model_edge();
      logic [15:0] srcs[4];
      wr_t w;
      srcs[0] = alu_result; srcs[1] = mem_data; srcs[2] = Imm; srcs[3] = in_port;
      if (!rst) begin
         pend.delete();
         exp_rw = 1'b0; exp_wa = '0; exp_wd = '0; exp_ret = 0;
      end else if (pend.size() > 0) begin
         w = pend.pop_front();
         exp_rw = 1'b1; exp_wa = w.a; exp_wd = w.d;
      end else if (in_valid) begin
         exp_rw  = WB_signals[2];
         exp_wa  = dst1;
         exp_wd  = srcs[WB_signals[1:0]];
         exp_ret = (exp_ret + 1) % 65536;
         if (dual && WB_signals[2]) begin
            w.a = dst2; w.d = alu_result2;
            pend.push_back(w);
         end
      end else begin
         exp_rw = 1'b0;
      end
      exp_stall = (pend.size() != 0);
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      in_valid = 0; WB_signals = 3'b000; dual = 0; dst1 = 0; dst2 = 0;
      alu_result = 0; alu_result2 = 0; mem_data = 0; Imm = 0; in_port = 0;
   endtask

   task automatic test_reset();
      set_idle();
      rst = 0; in_valid = 1; WB_signals = 3'b100; dst1 = 3'd7; alu_result = 16'hBEEF;
      tick(); tick();
      checks++;
      if ({regWrite, WA, WD, stall, retired} !== {1'b0, 3'd0, 16'h0, 1'b0, 16'h0}) begin
         failures++;
         $display("FAIL reset: rw=%0b wa=%0d wd=%h stall=%0b ret=%0d required all zero",
                  regWrite, WA, WD, stall, retired);
      end
      rst = 1; set_idle();
   endtask

   task automatic test_wbsel_sweep();
      logic [15:0] want[4];
      want[0] = 16'h1111; want[1] = 16'h2222; want[2] = 16'h3333; want[3] = 16'h4444;
      in_valid = 1; dual = 0; dst1 = 3'd3;
      alu_result = 16'h1111; mem_data = 16'h2222; Imm = 16'h3333; in_port = 16'h4444;
      for (int s = 0; s < 4; s++) begin
         WB_signals = {1'b1, 2'(s)};
         tick();
         checks++;
         if ({regWrite, WA, WD} !== {1'b1, 3'd3, want[s]}) begin
            failures++;
            $display("FAIL wbsel_%0d: rw=%0b wa=%0d wd=%h required rw=1 wa=3 wd=%h",
                     s, regWrite, WA, WD, want[s]);
         end
      end
      checks++;
      if (retired !== 16'd4) begin
         failures++;
         $display("FAIL wbsel_retired: got %0d required 4", retired);
      end
      set_idle();
      tick();
      checks++;
      if ({regWrite, WA, WD, retired} !== {1'b0, 3'd3, 16'h4444, 16'd4}) begin
         failures++;
         $display("FAIL bubble: rw=%0b wa=%0d wd=%h ret=%0d required rw=0 wa=3 wd=4444 ret=4",
                  regWrite, WA, WD, retired);
      end
   endtask

   task automatic issue_swap(input logic [2:0] a1, input logic [2:0] a2);
      in_valid = 1; dual = 1; WB_signals = 3'b100; dst1 = a1; dst2 = a2;
      alu_result = 16'hAAAA; alu_result2 = 16'h5555;
      tick();
   endtask

   task automatic test_swap();
      logic [15:0] r0;
      r0 = retired;
      issue_swap(3'd1, 3'd2);
      checks++;
      if ({regWrite, WA, WD, stall} !== {1'b1, 3'd1, 16'hAAAA, 1'b1}) begin
         failures++;
         $display("FAIL swap_first: rw=%0b wa=%0d wd=%h stall=%0b required 1/1/aaaa/1",
                  regWrite, WA, WD, stall);
      end
      set_idle();
      tick();
      checks++;
      if ({regWrite, WA, WD, stall} !== {1'b1, 3'd2, 16'h5555, 1'b0}) begin
         failures++;
         $display("FAIL swap_second: rw=%0b wa=%0d wd=%h stall=%0b required 1/2/5555/0",
                  regWrite, WA, WD, stall);
      end
      checks++;
      if (retired !== r0 + 16'd1) begin
         failures++;
         $display("FAIL swap_retired: got %0d required %0d", retired, r0 + 16'd1);
      end
   endtask

   task automatic test_stall_hold();
      issue_swap(3'd1, 3'd2);
      in_valid = 1; dual = 0; WB_signals = 3'b100; dst1 = 3'd4; alu_result = 16'h0F0F;
      tick();
      checks++;
      if ({regWrite, WA, WD, stall} !== {1'b1, 3'd2, 16'h5555, 1'b0}) begin
         failures++;
         $display("FAIL stall_ignore: rw=%0b wa=%0d wd=%h stall=%0b required 1/2/5555/0",
                  regWrite, WA, WD, stall);
      end
      tick();
      checks++;
      if ({regWrite, WA, WD} !== {1'b1, 3'd4, 16'h0F0F}) begin
         failures++;
         $display("FAIL stall_accept: rw=%0b wa=%0d wd=%h required 1/4/0f0f",
                  regWrite, WA, WD);
      end
      set_idle();
      tick();
   endtask

   task automatic test_dual_nowrite();
      in_valid = 1; dual = 1; WB_signals = 3'b000; dst1 = 3'd6; dst2 = 3'd7;
      alu_result = 16'h1234; alu_result2 = 16'h9999;
      tick();
      checks++;
      if ({regWrite, stall} !== 2'b00) begin
         failures++;
         $display("FAIL dual_nowrite: rw=%0b stall=%0b required 0/0", regWrite, stall);
      end
      set_idle();
      tick();
      checks++;
      if ({regWrite, stall} !== 2'b00) begin
         failures++;
         $display("FAIL dual_nowrite_second: rw=%0b stall=%0b required 0/0", regWrite, stall);
      end
   endtask

   task automatic test_same_dst();
      issue_swap(3'd5, 3'd5);
      checks++;
      if ({regWrite, WA, WD} !== {1'b1, 3'd5, 16'hAAAA}) begin
         failures++;
         $display("FAIL same_dst_first: rw=%0b wa=%0d wd=%h required 1/5/aaaa", regWrite, WA, WD);
      end
      set_idle();
      tick();
      checks++;
      if ({regWrite, WA, WD} !== {1'b1, 3'd5, 16'h5555}) begin
         failures++;
         $display("FAIL same_dst_second: rw=%0b wa=%0d wd=%h required 1/5/5555", regWrite, WA, WD);
      end
   endtask

   task automatic test_reset_mid_swap();
      issue_swap(3'd1, 3'd2);
      rst = 0; set_idle();
      tick();
      checks++;
      if ({regWrite, WA, WD, stall, retired} !== {1'b0, 3'd0, 16'h0, 1'b0, 16'h0}) begin
         failures++;
         $display("FAIL reset_mid_swap: rw=%0b wa=%0d wd=%h stall=%0b ret=%0d required all zero",
                  regWrite, WA, WD, stall, retired);
      end
      rst = 1;
      tick();
      checks++;
      if ({regWrite, WA, stall} !== {1'b0, 3'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset_mid_swap_drop: rw=%0b wa=%0d stall=%0b required 0/0/0",
                  regWrite, WA, stall);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst         = ($urandom_range(0, 39) != 0);
         in_valid    = ($urandom_range(0, 3) != 0);
         WB_signals  = 3'($urandom);
         dual        = ($urandom_range(0, 2) == 0);
         dst1        = 3'($urandom);
         dst2        = 3'($urandom);
         alu_result  = 16'($urandom);
         alu_result2 = 16'($urandom);
         mem_data    = 16'($urandom);
         Imm         = 16'($urandom);
         in_port     = 16'($urandom);
         tick();
         checks++;
         if ({regWrite, WA, WD, stall, retired} !==
             {exp_rw, exp_wa, exp_wd, exp_stall, 16'(exp_ret)}) begin
            failures++;
            $display("FAIL random_%0d: rw=%0b wa=%0d wd=%h stall=%0b ret=%0d required rw=%0b wa=%0d wd=%h stall=%0b ret=%0d",
                     i, regWrite, WA, WD, stall, retired,
                     exp_rw, exp_wa, exp_wd, exp_stall, exp_ret);
         end
      end
      rst = 1; set_idle();
      tick(); tick();
   endtask

   task automatic test_retired_wrap();
      rst = 0; set_idle();
      tick();
      rst = 1; in_valid = 1; dual = 0; WB_signals = 3'b100; dst1 = 3'd1;
      for (int i = 0; i < 65535; i++) tick();
      checks++;
      if (retired !== 16'hFFFF) begin
         failures++;
         $display("FAIL retired_preload: got %h required ffff", retired);
      end
      tick();
      checks++;
      if (retired !== 16'h0000) begin
         failures++;
         $display("FAIL retired_wrap: got %h required 0000", retired);
      end
      set_idle();
   endtask

   initial begin
      rst = 0;
      set_idle();
      exp_rw = 0; exp_wa = 0; exp_wd = 0; exp_stall = 0; exp_ret = 0;
      @(negedge clk);
      test_reset();
      test_wbsel_sweep();
      test_swap();
      test_stall_hold();
      test_dual_nowrite();
      test_same_dst();
      test_reset_mid_swap();
      test_random();
      test_retired_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
